// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/busy/done handshake and operand/result bundle for seq_divider
interface seq_divider_if #(
    parameter int w = 32
);
    logic         start;
    logic [w-1:0] dividend;
    logic [w-1:0] divisor;
    logic [w-1:0] quotient;
    logic [w-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative unsigned restoring divider, one quotient bit per clock
module seq_divider #(
    parameter int w = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_divider_if.slave bus
);
    localparam int CNT_W = (w > 2) ? $clog2(w) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(w - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t       state;
    logic [w-1:0] r;
    logic [w-1:0] q;
    logic [w-1:0] d;
    logic [CNT_W-1:0] cnt;
    logic         dbz;

    logic [w-1:0] quotient_r;
    logic [w-1:0] remainder_r;
    logic         busy_r;
    logic         done_r;
    logic         dbz_out_r;

    // Shifted partial remainder carries one extra bit so the compare cannot overflow.
    logic [w:0]   r_sh;
    logic         ge;
    logic [w-1:0] diff;

    always_comb begin
        r_sh = {r, q[w-1]};
        ge   = (r_sh >= {1'b0, d});
        diff = r_sh[w-1:0] - d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            dbz         <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_out_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        r         <= '0;
                        q         <= bus.dividend;
                        d         <= bus.divisor;
                        cnt       <= '0;
                        busy_r    <= 1'b1;
                        dbz_out_r <= 1'b0;
                        dbz       <= (bus.divisor == '0);
                        state     <= (bus.divisor == '0) ? FIN : RUN;
                    end
                end
                RUN: begin
                    r   <= ge ? diff : r_sh[w-1:0];
                    q   <= {q[w-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    // On divide-by-zero q still holds the untouched dividend.
                    quotient_r  <= dbz ? '1 : q;
                    remainder_r <= dbz ? q : r;
                    dbz_out_r   <= dbz;
                    done_r      <= 1'b1;
                    busy_r      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_out_r;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider (w=32)
`timescale 1ns/1ps
module tb_seq_divider;
    localparam int W = 32;
    localparam int BUDGET = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    seq_divider_if #(.w(W)) bus ();

    seq_divider #(.w(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    task automatic wait_done(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        while (edges < BUDGET) begin
            if (bus.busy) busy_cycles++;
            tick();
            edges++;
            if (bus.done) break;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_result: q=%h r=%h required 0/0", bus.quotient, bus.remainder);
        end
        n_checks++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/dbz=%b required 000", {bus.busy, bus.done, bus.div_by_zero});
        end
    endtask

    task automatic test_basic();
        int e, bc;
        start_op(32'd100, 32'd7);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_after_accept: busy=%b required 1", bus.busy);
        end
        wait_done(e, bc);
        n_checks++;
        if (e !== 33) begin
            n_fail++;
            $display("FAIL basic_latency: edges=%0d required 33", e);
        end
        n_checks++;
        if (bc !== 33) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: cycles=%0d required 33", bc);
        end
        n_checks++;
        if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2 || bus.div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_100_7: q=%0d r=%0d dbz=%b required 14 2 0", bus.quotient, bus.remainder, bus.div_by_zero);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_at_done: busy=%b required 0", bus.busy);
        end
        tick();
        n_checks++;
        if (bus.done !== 1'b0 || bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
            n_fail++;
            $display("FAIL basic_done_pulse_hold: done=%b q=%0d r=%0d required 0 14 2", bus.done, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] va [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3,  32'd1000};
        logic [W-1:0] vb [4] = '{32'd1,        32'hFFFF_FFFF, 32'd10, 32'd8};
        logic [W-1:0] vq [4] = '{32'hFFFF_FFFF, 32'd1,        32'd0,  32'd125};
        logic [W-1:0] vr [4] = '{32'd0,        32'd0,         32'd3,  32'd0};
        int e, bc;
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i]);
            wait_done(e, bc);
            n_checks++;
            if (e !== 33 || bus.quotient !== vq[i] || bus.remainder !== vr[i]) begin
                n_fail++;
                $display("FAIL boundary_%0d: edges=%0d q=%h r=%h required 33 %h %h", i, e, bus.quotient, bus.remainder, vq[i], vr[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int e, bc;
        start_op(32'd5, 32'd0);
        wait_done(e, bc);
        n_checks++;
        if (e !== 1) begin
            n_fail++;
            $display("FAIL dbz_latency: edges=%0d required 1", e);
        end
        n_checks++;
        if (bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 32'd5 || bus.div_by_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL dbz_result: q=%h r=%0d dbz=%b required ffffffff 5 1", bus.quotient, bus.remainder, bus.div_by_zero);
        end
        tick();
        n_checks++;
        if (bus.div_by_zero !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL dbz_hold: dbz=%b done=%b required 1 0", bus.div_by_zero, bus.done);
        end
        start_op(32'd9, 32'd3);
        n_checks++;
        if (bus.div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL dbz_clear_on_start: dbz=%b required 0", bus.div_by_zero);
        end
        wait_done(e, bc);
        n_checks++;
        if (e !== 33 || bus.quotient !== 32'd3 || bus.remainder !== 32'd0 || bus.div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL dbz_then_9_3: edges=%0d q=%0d r=%0d dbz=%b required 33 3 0 0", e, bus.quotient, bus.remainder, bus.div_by_zero);
        end
    endtask

    task automatic test_back_to_back();
        int e, bc;
        start_op(32'd100, 32'd7);
        repeat (9) tick();
        start_op(32'd50, 32'd5);
        wait_done(e, bc);
        n_checks++;
        if (e + 10 !== 33 || bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
            n_fail++;
            $display("FAIL busy_ignore: edges=%0d q=%0d r=%0d required 33 14 2", e + 10, bus.quotient, bus.remainder);
        end
        start_op(32'd50, 32'd5);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b required 1 0", bus.busy, bus.done);
        end
        wait_done(e, bc);
        n_checks++;
        if (e !== 33 || bus.quotient !== 32'd10 || bus.remainder !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b_50_5: edges=%0d q=%0d r=%0d required 33 10 0", e, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_reset_abort();
        int e, bc;
        int seen = 0;
        start_op(32'd1000, 32'd3);
        repeat (11) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (bus.quotient !== 32'd0 || bus.remainder !== 32'd0 ||
            {bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_outputs: q=%h r=%h flags=%b required 0 0 000", bus.quotient, bus.remainder, {bus.busy, bus.done, bus.div_by_zero});
        end
        for (int i = 0; i < 40; i++) begin
            if (bus.done) seen++;
            tick();
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: done_cycles=%0d required 0", seen);
        end
        start_op(32'd1000, 32'd3);
        wait_done(e, bc);
        n_checks++;
        if (e !== 33 || bus.quotient !== 32'd333 || bus.remainder !== 32'd1) begin
            n_fail++;
            $display("FAIL abort_rerun: edges=%0d q=%0d r=%0d required 33 333 1", e, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] a, b;
        int e, bc;
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = 32'd1;
                1: begin
                    b = $urandom | 32'h8000_0000;
                    a = $urandom_range(b - 1, 0);
                end
                2: b = 32'd1 << $urandom_range(31, 0);
                default: b = $urandom >> $urandom_range(31, 0);
            endcase
            if (b == 0) b = 32'd1;
            start_op(a, b);
            wait_done(e, bc);
            n_checks++;
            if (e !== 33 || bus.quotient !== a / b || bus.remainder !== a % b || bus.div_by_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL vector_%0d: %h/%h edges=%0d q=%h r=%h required 33 %h %h", i, a, b, e, bus.quotient, bus.remainder, a / b, a % b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
        test_vectors();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
